// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request and hazard/forwarding response bundle for fwd_hazard_unit.
// The master side drives pipeline control and ID attributes; the slave side is the hazard unit.
interface fwd_hazard_unit_if #(
    parameter int AW   = 4,
    parameter int NSRC = 2,
    parameter int CW   = 8
);
    logic                 en;
    logic                 flush;
    logic                 cnt_clr;
    logic                 id_valid;
    logic                 id_regwrite;
    logic                 id_memread;
    logic                 id_memwrite;
    logic [AW-1:0]        id_dst;
    logic [NSRC*AW-1:0]   id_src;
    logic [NSRC-1:0]      id_src_used;
    logic [2*NSRC-1:0]    ex_fwd_sel;
    logic                 stall_id;
    logic                 mem_fwd_store;
    logic [CW-1:0]        stall_cnt;

    modport master (
        output en, flush, cnt_clr,
        output id_valid, id_regwrite, id_memread, id_memwrite,
        output id_dst, id_src, id_src_used,
        input  ex_fwd_sel, stall_id, mem_fwd_store, stall_cnt
    );

    modport slave (
        input  en, flush, cnt_clr,
        input  id_valid, id_regwrite, id_memread, id_memwrite,
        input  id_dst, id_src, id_src_used,
        output ex_fwd_sel, stall_id, mem_fwd_store, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Tracks register tags through EX/MEM/WB and derives operand forwarding selects,
// load-use stalls, load-to-store data forwarding and a saturating stall counter.
module fwd_hazard_unit #(
    parameter int AW      = 4,
    parameter int NSRC    = 2,
    parameter int ST_IDX  = 1,
    parameter int ZERO_HW = 1,
    parameter int CW      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_hazard_unit_if.slave  bus
);

    typedef struct packed {
        logic               valid;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic [AW-1:0]      dst;
        logic [NSRC*AW-1:0] src;
        logic [NSRC-1:0]    src_used;
    } stage_t;

    stage_t             id_stage;
    stage_t             ex_q, ex_d;
    stage_t             mem_q, mem_d;
    stage_t             wb_q, wb_d;
    logic [CW-1:0]      stall_cnt_q, stall_cnt_d;
    logic               ex_wr, mem_wr, wb_wr;
    logic               stall;
    logic [NSRC-1:0]    ld_match;
    logic [2*NSRC-1:0]  fwd_sel;
    logic               fwd_store;
    logic               unused_wb;

    // A stage only produces a forwardable value when it really writes a non-hardwired register.
    function automatic logic is_writer(stage_t s);
        return s.valid & s.regwrite & ((ZERO_HW == 0) | (s.dst != '0));
    endfunction

    assign ex_wr  = is_writer(ex_q);
    assign mem_wr = is_writer(mem_q);
    assign wb_wr  = is_writer(wb_q);

    always_comb begin
        id_stage          = '0;
        id_stage.valid    = bus.id_valid;
        id_stage.regwrite = bus.id_regwrite;
        id_stage.memread  = bus.id_memread;
        id_stage.memwrite = bus.id_memwrite;
        id_stage.dst      = bus.id_dst;
        id_stage.src      = bus.id_src;
        id_stage.src_used = bus.id_src_used;
    end

    // Load data is not yet available in MEM, so a MEM-stage load never feeds EX directly.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (ex_q.src_used[i] && mem_wr && !mem_q.memread &&
                (mem_q.dst == ex_q.src[i*AW +: AW])) begin
                fwd_sel[2*i +: 2] = 2'b10;
            end else if (ex_q.src_used[i] && wb_wr &&
                         (wb_q.dst == ex_q.src[i*AW +: AW])) begin
                fwd_sel[2*i +: 2] = 2'b01;
            end
        end
    end

    // Store data from a load is picked up later in MEM, so that operand alone does not stall.
    always_comb begin
        ld_match = '0;
        for (int i = 0; i < NSRC; i++) begin
            ld_match[i] = bus.id_src_used[i] & (bus.id_src[i*AW +: AW] == ex_q.dst);
        end
        if (bus.id_memwrite) begin
            ld_match[ST_IDX] = 1'b0;
        end
        stall = bus.id_valid & ex_wr & ex_q.memread & (|ld_match);
    end

    assign fwd_store = mem_q.valid & mem_q.memwrite & mem_q.src_used[ST_IDX] &
                       wb_wr & wb_q.memread &
                       (wb_q.dst == mem_q.src[ST_IDX*AW +: AW]);

    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_cnt_d = stall_cnt_q;
        if (bus.en) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = (bus.id_valid && !stall && !bus.flush) ? id_stage : '0;
            if (bus.cnt_clr) begin
                stall_cnt_d = '0;
            end else if (stall && (stall_cnt_q != {CW{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // WB is the last stage, so its store/source fields are never looked at again.
    assign unused_wb = ^{wb_q.memwrite, wb_q.src, wb_q.src_used};

    assign bus.ex_fwd_sel    = fwd_sel;
    assign bus.stall_id      = stall;
    assign bus.mem_fwd_store = fwd_store;
    assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: a table of ID instructions with expected hazard outputs,
// followed by hand-written sequences for counter saturation, freeze, clear, flush and reset.
module tb_fwd_hazard_unit;

    localparam int AW   = 4;
    localparam int NSRC = 2;
    localparam int CW   = 2;
    localparam int NVEC = 27;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    fwd_hazard_unit_if #(.AW(AW), .NSRC(NSRC), .CW(CW)) bus ();

    fwd_hazard_unit #(
        .AW(AW), .NSRC(NSRC), .ST_IDX(1), .ZERO_HW(1), .CW(CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v, rw, mr, mw;
        logic [3:0] dst, s0, s1;
        logic [1:0] used;
        logic       fl;
        logic [3:0] fwd;
        logic       stall;
        logic       mfs;
        logic [1:0] cnt;
    } vec_t;

    vec_t vecs [NVEC];
    vec_t nop;

    function automatic vec_t mk(input logic v, input logic rw, input logic mr, input logic mw,
                                input logic [3:0] dst, input logic [3:0] s0, input logic [3:0] s1,
                                input logic [1:0] used, input logic fl, input logic [3:0] fwd,
                                input logic stall, input logic mfs, input logic [1:0] cnt);
        vec_t r;
        r.v = v; r.rw = rw; r.mr = mr; r.mw = mw;
        r.dst = dst; r.s0 = s0; r.s1 = s1; r.used = used; r.fl = fl;
        r.fwd = fwd; r.stall = stall; r.mfs = mfs; r.cnt = cnt;
        return r;
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.id_valid    = v.v;
        bus.id_regwrite = v.rw;
        bus.id_memread  = v.mr;
        bus.id_memwrite = v.mw;
        bus.id_dst      = v.dst;
        bus.id_src      = {v.s1, v.s0};
        bus.id_src_used = v.used;
        bus.flush       = v.fl;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        check({tag, ".fwd"},   32'(bus.ex_fwd_sel),    32'(v.fwd));
        check({tag, ".stall"}, 32'(bus.stall_id),      32'(v.stall));
        check({tag, ".mfs"},   32'(bus.mem_fwd_store), 32'(v.mfs));
        check({tag, ".cnt"},   32'(bus.stall_cnt),     32'(v.cnt));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nop = mk(0,0,0,0, 4'd0,4'd0,4'd0, 2'b00, 0, 4'b0000,0,0,2'd0);

        //             v rw mr mw dst   s0    s1    used   fl  fwd     st mfs cnt
        vecs[0]  = mk(1,1,0,0, 4'd3, 4'd1, 4'd2, 2'b11, 0, 4'b0000,0,0,2'd0);
        vecs[1]  = mk(1,1,0,0, 4'd6, 4'd3, 4'd7, 2'b11, 0, 4'b0000,0,0,2'd0);
        vecs[2]  = mk(1,1,0,0, 4'd8, 4'd3, 4'd9, 2'b11, 0, 4'b0010,0,0,2'd0);
        vecs[3]  = mk(0,0,0,0, 4'd0, 4'd0, 4'd0, 2'b00, 0, 4'b0001,0,0,2'd0);
        vecs[4]  = mk(1,1,0,0, 4'd5, 4'd1, 4'd0, 2'b01, 0, 4'b0000,0,0,2'd0);
        vecs[5]  = mk(1,1,0,0, 4'd5, 4'd2, 4'd2, 2'b11, 0, 4'b0000,0,0,2'd0);
        vecs[6]  = mk(1,1,0,0, 4'd10,4'd4, 4'd5, 2'b11, 0, 4'b0000,0,0,2'd0);
        vecs[7]  = mk(0,0,0,0, 4'd0, 4'd0, 4'd0, 2'b00, 0, 4'b1000,0,0,2'd0);
        vecs[8]  = mk(1,1,1,0, 4'd4, 4'd1, 4'd0, 2'b01, 0, 4'b0000,0,0,2'd0);
        vecs[9]  = mk(1,1,0,0, 4'd11,4'd4, 4'd2, 2'b11, 0, 4'b0000,1,0,2'd0);
        vecs[10] = mk(1,1,0,0, 4'd11,4'd4, 4'd2, 2'b11, 0, 4'b0000,0,0,2'd1);
        vecs[11] = mk(0,0,0,0, 4'd0, 4'd0, 4'd0, 2'b00, 0, 4'b0001,0,0,2'd1);
        vecs[12] = mk(1,1,1,0, 4'd4, 4'd1, 4'd0, 2'b01, 0, 4'b0000,0,0,2'd1);
        vecs[13] = mk(1,0,0,1, 4'd0, 4'd2, 4'd4, 2'b11, 0, 4'b0000,0,0,2'd1);
        vecs[14] = mk(0,0,0,0, 4'd0, 4'd0, 4'd0, 2'b00, 0, 4'b0000,0,0,2'd1);
        vecs[15] = mk(0,0,0,0, 4'd0, 4'd0, 4'd0, 2'b00, 0, 4'b0000,0,1,2'd1);
        vecs[16] = mk(1,1,1,0, 4'd4, 4'd1, 4'd0, 2'b01, 0, 4'b0000,0,0,2'd1);
        vecs[17] = mk(1,0,0,1, 4'd0, 4'd4, 4'd4, 2'b11, 0, 4'b0000,1,0,2'd1);
        vecs[18] = mk(0,0,0,0, 4'd0, 4'd0, 4'd0, 2'b00, 0, 4'b0000,0,0,2'd2);
        vecs[19] = mk(1,1,1,0, 4'd0, 4'd1, 4'd0, 2'b01, 0, 4'b0000,0,0,2'd2);
        vecs[20] = mk(1,1,0,0, 4'd0, 4'd0, 4'd0, 2'b11, 0, 4'b0000,0,0,2'd2);
        vecs[21] = mk(1,1,0,0, 4'd2, 4'd0, 4'd0, 2'b11, 0, 4'b0000,0,0,2'd2);
        vecs[22] = mk(0,0,0,0, 4'd0, 4'd0, 4'd0, 2'b00, 0, 4'b0000,0,0,2'd2);
        vecs[23] = mk(1,1,1,0, 4'd4, 4'd1, 4'd0, 2'b01, 0, 4'b0000,0,0,2'd2);
        vecs[24] = mk(0,1,1,0, 4'd4, 4'd4, 4'd4, 2'b11, 0, 4'b0000,0,0,2'd2);
        vecs[25] = mk(1,1,0,0, 4'd7, 4'd4, 4'd4, 2'b11, 1, 4'b0000,0,0,2'd2);
        vecs[26] = mk(0,0,0,0, 4'd0, 4'd0, 4'd0, 2'b00, 0, 4'b0000,0,0,2'd2);

        bus.en      = 1'b1;
        bus.cnt_clr = 1'b0;
        applyStimulus(nop);
        #12;
        checkOutput("in_reset", nop);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("after_reset", nop);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d", i), vecs[i]);
            step();
        end

        // en=0 must ignore cnt_clr; then a real clear.
        applyStimulus(nop);
        bus.en      = 1'b0;
        bus.cnt_clr = 1'b1;
        step();
        check("en0_clr_ignored", 32'(bus.stall_cnt), 32'd2);
        bus.en = 1'b1;
        step();
        bus.cnt_clr = 1'b0;
        check("cnt_clr", 32'(bus.stall_cnt), 32'd0);

        // Self-dependent load chain stalls every other cycle; counter saturates at 3.
        applyStimulus(mk(1,1,1,0, 4'd4,4'd4,4'd0, 2'b01, 0, 4'b0000,0,0,2'd0));
        step();
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("sat%0d.stall_on", k), 32'(bus.stall_id), 32'd1);
            check($sformatf("sat%0d.cnt", k), 32'(bus.stall_cnt), (k < 3) ? 32'(k) : 32'd3);
            step();
            check($sformatf("sat%0d.stall_off", k), 32'(bus.stall_id), 32'd0);
            step();
        end
        check("sat_final", 32'(bus.stall_cnt), 32'd3);

        // Freeze with stall pending, flush and clear requested.
        bus.en      = 1'b0;
        bus.flush   = 1'b1;
        bus.cnt_clr = 1'b1;
        repeat (3) step();
        check("freeze.stall", 32'(bus.stall_id), 32'd1);
        check("freeze.cnt", 32'(bus.stall_cnt), 32'd3);

        // Clear beats a simultaneous increment.
        bus.en    = 1'b1;
        bus.flush = 1'b0;
        #1;
        check("clr_vs_inc.stall", 32'(bus.stall_id), 32'd1);
        step();
        bus.cnt_clr = 1'b0;
        check("clr_vs_inc.cnt", 32'(bus.stall_cnt), 32'd0);

        // Flush coincident with a stall counts once and leaves a bubble.
        step();
        bus.flush = 1'b1;
        #1;
        check("flush_stall.stall", 32'(bus.stall_id), 32'd1);
        step();
        bus.flush = 1'b0;
        check("flush_stall.cnt", 32'(bus.stall_cnt), 32'd1);
        applyStimulus(nop);
        #1;
        check("flush_stall.fwd", 32'(bus.ex_fwd_sel), 32'd0);

        // Reset in the middle of an active MEM forward.
        applyStimulus(mk(1,1,0,0, 4'd3,4'd1,4'd2, 2'b11, 0, 4'b0000,0,0,2'd0));
        step();
        applyStimulus(mk(1,1,0,0, 4'd6,4'd3,4'd7, 2'b11, 0, 4'b0000,0,0,2'd0));
        step();
        applyStimulus(nop);
        #1;
        check("pre_rst.fwd", 32'(bus.ex_fwd_sel), 32'b0010);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst", nop);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("post_rst", nop);
        step();
        checkOutput("post_rst2", nop);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter AW, default 4, register-tag width (2^AW architectural registers).
REQ-002 Parameter NSRC, default 2, source operands per instruction.
REQ-003 Parameter ST_IDX, default 1, source index carrying store data.
REQ-004 Parameter ZERO_HW, default 1; 1 = register 0 hardwired, never forwarded or stalled on.
REQ-005 Parameter CW, default 8, stall-counter width.
REQ-006 clk  in  1  single clock, all state rising-edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 en  in  1  pipeline advance; 0 freezes all internal state and the counter.
REQ-009 flush  in  1  squash the ID instruction; a bubble enters EX.
REQ-010 id_valid, id_regwrite, id_memread, id_memwrite  in  1 each  ID-stage instruction attributes.
REQ-011 id_dst  in  AW  ID destination tag.
REQ-012 id_src  in  NSRC*AW  ID source tags; source i is at bits [i*AW +: AW].
REQ-013 id_src_used  in  NSRC  per-source "operand is read" qualifier.
REQ-014 cnt_clr  in  1  synchronous clear of stall_cnt.
REQ-015 ex_fwd_sel  out  2*NSRC  per EX source: 00 register file, 10 EX/MEM result, 01 MEM/WB data.
REQ-016 stall_id  out  1  load-use stall: hold IF/ID; a bubble enters EX.
REQ-017 mem_fwd_store  out  1  MEM-stage store data taken from the MEM/WB load data.
REQ-018 stall_cnt  out  CW  saturating count of stall cycles.

Function
REQ-019 Three internal tag stages EX, MEM, WB; each holds valid, regwrite, memread, memwrite, dst, srcs, src_used.
REQ-020 Edge with en=1: WB<=MEM, MEM<=EX; EX<=ID when id_valid & ~stall_id & ~flush, else EX<=bubble (valid=0).
REQ-021 Edge with en=0: all stages and stall_cnt hold; flush and cnt_clr ignored.
REQ-022 Writer qualifier for a stage: valid & regwrite & (dst!=0 when ZERO_HW=1).
REQ-023 ex_fwd_sel[i]=10 when EX.src_used[i] & MEM writer & ~MEM.memread & MEM.dst==EX.src[i].
REQ-024 Else ex_fwd_sel[i]=01 when EX.src_used[i] & WB writer & WB.dst==EX.src[i].
REQ-025 Else ex_fwd_sel[i]=00; MEM has strict priority over WB for the same source.
REQ-026 stall_id=1 when id_valid & EX writer & EX.memread & some used source i with id_src[i]==EX.dst, excepting REQ-027.
REQ-027 No stall when the only matching source is ST_IDX and id_memwrite=1; store data is covered by REQ-028.
REQ-028 mem_fwd_store=1 when MEM.valid & MEM.memwrite & MEM.src_used[ST_IDX] & WB writer & WB.memread & WB.dst==MEM.src[ST_IDX].
REQ-029 ex_fwd_sel, stall_id, mem_fwd_store are combinational from current stage state and ID inputs; zero added latency.
REQ-030 stall_cnt increments on an edge with en=1 & stall_id=1, saturating at 2^CW-1, no wrap.
REQ-031 cnt_clr with en=1 sets stall_cnt to 0 and wins over a simultaneous increment.
REQ-032 flush and stall_id together produce a single bubble; no double count beyond REQ-030.
REQ-033 An ID instruction with id_valid=0 never stalls and never enters EX as valid.

Reset
REQ-034 rst_n low asynchronously clears all stage valid bits, tags and stall_cnt to 0.
REQ-035 During and directly after reset: ex_fwd_sel=0, stall_id=0, mem_fwd_store=0.
REQ-036 Reset asserted mid-stall or mid-forward discards all in-flight tags; there is no residual forwarding after release.

Verification
REQ-037 ADD r3 then SUB using r3 as src0 -> SUB in EX: ex_fwd_sel[1:0]=10; one cycle later as WB-only match: 01.
REQ-038 Writes to r5 in MEM (ALU) and in WB, EX reads r5 as src1 -> ex_fwd_sel[3:2]=10 (priority).
REQ-039 LW r4 in EX, ID ADD reads r4 as src0 -> stall_id=1 for one cycle, stall_cnt 0->1; then ex_fwd_sel[1:0]=01.
REQ-040 LW r4 then SW with r4 as store data (src1) -> no stall; when SW is in MEM, mem_fwd_store=1.
REQ-041 ZERO_HW=1: writer dst r0, reader src r0 -> ex_fwd_sel=00 and stall_id=0 even after a load to r0.
REQ-042 CW=2, stall held for 5 cycles with en=1 -> stall_cnt saturates at 3; en=0 freezes; cnt_clr -> 0; rst_n pulse mid-run -> all outputs 0.
